// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: funct3 codes, FSM states, error codes
// and the small decode helpers used when a request is accepted.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_ERR   = 2'd3;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_ILLEGAL  = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } lsu_err_e;

  // Highest valid bit of the access: byte 7, half 15, word width-1.
  function automatic int unsigned lane_msb(input logic [2:0] f3, input int unsigned width);
    case (f3[1:0])
      2'b00:   return 32'd7;
      2'b01:   return 32'd15;
      default: return width - 32'd1;
    endcase
  endfunction

  function automatic logic is_illegal(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 > F3_W);
    return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
  endfunction

  function automatic logic is_misaligned(input logic is_store, input logic [2:0] f3,
                                         input logic [1:0] addr_lo);
    logic half;
    logic word;
    half = (f3 == F3_H) || (!is_store && (f3 == F3_HU));
    word = (f3 == F3_W);
    return (half && addr_lo[0]) || (word && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Combinational load-data extension: sign- or zero-extends the low byte/half of the
// raw memory word according to the load funct3; words pass straight through.
module lsu_load_extend
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       funct3_i,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] data_o
);

  always_comb begin
    data_o = raw_i;
    case (funct3_i)
      F3_B:    data_o = {{(WIDTH-8){raw_i[7]}}, raw_i[7:0]};
      F3_H:    data_o = {{(WIDTH-16){raw_i[15]}}, raw_i[15:0]};
      F3_BU:   data_o = {{(WIDTH-8){1'b0}}, raw_i[7:0]};
      F3_HU:   data_o = {{(WIDTH-16){1'b0}}, raw_i[15:0]};
      default: data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RV32 load/store unit mastering the generic rd/wr memory
// interfaces, with misalignment, illegal-funct3 and response-timeout reporting.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | ready for a request; resp_valid may be high for the previous one
// ST_READ  | rd_enable held, waiting for rd_response or timeout
// ST_WRITE | wr_valid held, waiting for wr_response or timeout
// ST_ERR   | rejected request, reports its error code next cycle
module load_store_unit
  import lsu_pkg::*;
#(
  parameter  int WIDTH   = 32,
  parameter  int DEPTH   = 65536,
  parameter  int TIMEOUT = 255,
  localparam int ADDR_W  = $clog2(DEPTH),
  localparam int IDX_W   = $clog2(WIDTH)
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_is_store_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [31:0]       req_address_i,
  input  logic [WIDTH-1:0]  req_wdata_i,
  output logic              resp_valid_o,
  output logic [WIDTH-1:0]  resp_rdata_o,
  output logic [1:0]        resp_error_o,
  output logic [ADDR_W-1:0] rd_address_o,
  output logic              rd_enable_o,
  output logic [IDX_W-1:0]  rd_index_o,
  input  logic              rd_response_i,
  input  logic [WIDTH-1:0]  rd_data_i,
  output logic [ADDR_W-1:0] wr_address_o,
  output logic              wr_valid_o,
  output logic [WIDTH-1:0]  wr_data_o,
  output logic [IDX_W-1:0]  wr_index_o,
  input  logic              wr_response_i
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  lsu_err_e          err_q, err_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] rd_address_q, rd_address_d;
  logic              rd_enable_q, rd_enable_d;
  logic [IDX_W-1:0]  rd_index_q, rd_index_d;
  logic [ADDR_W-1:0] wr_address_q, wr_address_d;
  logic              wr_valid_q, wr_valid_d;
  logic [WIDTH-1:0]  wr_data_q, wr_data_d;
  logic [IDX_W-1:0]  wr_index_q, wr_index_d;
  logic              resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0]  resp_rdata_q, resp_rdata_d;
  logic [1:0]        resp_error_q, resp_error_d;

  logic [ADDR_W-1:0] req_addr;
  logic [IDX_W-1:0]  req_idx;
  logic              req_misalign;
  logic              req_illegal;
  logic [WIDTH-1:0]  ext_data;
  logic              unused_addr_hi;

  assign req_addr       = req_address_i[ADDR_W-1:0];
  assign unused_addr_hi = ^req_address_i[31:ADDR_W];
  assign req_idx        = IDX_W'(lane_msb(req_funct3_i, WIDTH));
  assign req_misalign   = is_misaligned(req_is_store_i, req_funct3_i, req_address_i[1:0]);
  assign req_illegal    = is_illegal(req_is_store_i, req_funct3_i);

  lsu_load_extend #(.WIDTH(WIDTH)) u_extend (
    .funct3_i (f3_q),
    .raw_i    (rd_data_i),
    .data_o   (ext_data)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    f3_d         = f3_q;
    rd_address_d = rd_address_q;
    rd_enable_d  = rd_enable_q;
    rd_index_d   = rd_index_q;
    wr_address_d = wr_address_q;
    wr_valid_d   = wr_valid_q;
    wr_data_d    = wr_data_q;
    wr_index_d   = wr_index_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_error_d = resp_error_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          f3_d  = req_funct3_i;
          cnt_d = '0;
          if (req_misalign) begin
            state_d = ST_ERR;
            err_d   = ERR_MISALIGN;
          end else if (req_illegal) begin
            state_d = ST_ERR;
            err_d   = ERR_ILLEGAL;
          end else if (req_is_store_i) begin
            state_d      = ST_WRITE;
            wr_valid_d   = 1'b1;
            wr_address_d = req_addr;
            wr_index_d   = req_idx;
            wr_data_d    = req_wdata_i;
          end else begin
            state_d      = ST_READ;
            rd_enable_d  = 1'b1;
            rd_address_d = req_addr;
            rd_index_d   = req_idx;
          end
        end
      end
      ST_READ: begin
        if (rd_response_i || (cnt_q == TO_LAST)) begin
          state_d      = ST_IDLE;
          rd_enable_d  = 1'b0;
          rd_address_d = '0;
          rd_index_d   = '0;
          resp_valid_d = 1'b1;
          resp_rdata_d = rd_response_i ? ext_data : '0;
          resp_error_d = rd_response_i ? ERR_OK : ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WRITE: begin
        if (wr_response_i || (cnt_q == TO_LAST)) begin
          state_d      = ST_IDLE;
          wr_valid_d   = 1'b0;
          wr_address_d = '0;
          wr_index_d   = '0;
          wr_data_d    = '0;
          resp_valid_d = 1'b1;
          resp_rdata_d = '0;
          resp_error_d = wr_response_i ? ERR_OK : ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ERR: begin
        state_d      = ST_IDLE;
        resp_valid_d = 1'b1;
        resp_rdata_d = '0;
        resp_error_d = err_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      err_q        <= ERR_OK;
      f3_q         <= '0;
      rd_address_q <= '0;
      rd_enable_q  <= 1'b0;
      rd_index_q   <= '0;
      wr_address_q <= '0;
      wr_valid_q   <= 1'b0;
      wr_data_q    <= '0;
      wr_index_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_error_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      f3_q         <= f3_d;
      rd_address_q <= rd_address_d;
      rd_enable_q  <= rd_enable_d;
      rd_index_q   <= rd_index_d;
      wr_address_q <= wr_address_d;
      wr_valid_q   <= wr_valid_d;
      wr_data_q    <= wr_data_d;
      wr_index_q   <= wr_index_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
    end
  end

  assign req_ready_o  = (state_q == ST_IDLE);
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_error_o = resp_error_q;
  assign rd_address_o = rd_address_q;
  assign rd_enable_o  = rd_enable_q;
  assign rd_index_o   = rd_index_q;
  assign wr_address_o = wr_address_q;
  assign wr_valid_o   = wr_valid_q;
  assign wr_data_o    = wr_data_q;
  assign wr_index_o   = wr_index_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stimulus tasks push expected responses into a
// queue, an independent monitor pops and compares on every resp_valid.
module tb_load_store_unit;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_address = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_error;
  logic [15:0] rd_address;
  logic        rd_enable;
  logic [4:0]  rd_index;
  logic        rd_response = 1'b0;
  logic [31:0] rd_data = 32'd0;
  logic [15:0] wr_address;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic [4:0]  wr_index;
  logic        wr_response = 1'b0;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clock = ~clock;

  load_store_unit #(.WIDTH(32), .DEPTH(65536), .TIMEOUT(4)) dut (
    .clock_i        (clock),
    .reset_n_i      (reset_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_is_store_i (req_is_store),
    .req_funct3_i   (req_funct3),
    .req_address_i  (req_address),
    .req_wdata_i    (req_wdata),
    .resp_valid_o   (resp_valid),
    .resp_rdata_o   (resp_rdata),
    .resp_error_o   (resp_error),
    .rd_address_o   (rd_address),
    .rd_enable_o    (rd_enable),
    .rd_index_o     (rd_index),
    .rd_response_i  (rd_response),
    .rd_data_i      (rd_data),
    .wr_address_o   (wr_address),
    .wr_valid_o     (wr_valid),
    .wr_data_o      (wr_data),
    .wr_index_o     (wr_index),
    .wr_response_i  (wr_response)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_resp(input logic [31:0] rdata, input logic [1:0] err);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    if (reset_n && resp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: resp_valid with rdata 0x%08h err %0d, none expected at %0t",
                 resp_rdata, resp_error, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_error", {30'd0, resp_error}, {30'd0, e.err});
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check("idle_no_resp", resp_valid, 0);
      check("idle_ready", req_ready, 1);
    end
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] raw,
                         input int k, input logic [4:0] idx, input logic [31:0] exp_data);
    check("load_ready", req_ready, 1);
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = f3; req_address = addr;
    req_wdata = 32'h0BAD_0BAD;
    expect_resp(exp_data, 2'b00);
    for (int c = 1; c <= k; c++) begin
      @(negedge clock);
      req_valid = 1'b0;
      check("rd_enable", rd_enable, 1);
      check("rd_address", {16'd0, rd_address}, {16'd0, addr[15:0]});
      check("rd_index", {27'd0, rd_index}, {27'd0, idx});
      check("wr_valid_in_load", wr_valid, 0);
      check("ready_busy", req_ready, 0);
      if (c == k) begin
        rd_response = 1'b1;
        rd_data     = raw;
      end
    end
    @(negedge clock);
    rd_response = 1'b0;
    rd_data     = 32'h0;
    check("rd_enable_drop", rd_enable, 0);
    check("load_resp_valid", resp_valid, 1);
    check("ready_on_resp", req_ready, 1);
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                          input int k, input logic [4:0] idx);
    check("store_ready", req_ready, 1);
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = f3; req_address = addr;
    req_wdata = wdata;
    expect_resp(32'h0, 2'b00);
    for (int c = 1; c <= k; c++) begin
      @(negedge clock);
      req_valid = 1'b0;
      check("wr_valid", wr_valid, 1);
      check("wr_address", {16'd0, wr_address}, {16'd0, addr[15:0]});
      check("wr_index", {27'd0, wr_index}, {27'd0, idx});
      check("wr_data", wr_data, wdata);
      check("rd_enable_in_store", rd_enable, 0);
      if (c == k) wr_response = 1'b1;
    end
    @(negedge clock);
    wr_response = 1'b0;
    check("wr_valid_drop", wr_valid, 0);
    check("store_resp_valid", resp_valid, 1);
    check("rd_enable_after_store", rd_enable, 0);
  endtask

  task automatic do_err(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [1:0] code);
    check("err_ready", req_ready, 1);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_address = addr;
    req_wdata = 32'h1111_2222;
    expect_resp(32'h0, code);
    @(negedge clock);
    req_valid = 1'b0;
    check("err_no_rd", rd_enable, 0);
    check("err_no_wr", wr_valid, 0);
    check("err_busy", req_ready, 0);
    check("err_no_early_resp", resp_valid, 0);
    @(negedge clock);
    check("err_resp_valid", resp_valid, 1);
    check("err_no_rd_late", rd_enable, 0);
    check("err_no_wr_late", wr_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("rst_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_error", {30'd0, resp_error}, 0);
    check("rst_rd_enable", rd_enable, 0);
    check("rst_rd_address", {16'd0, rd_address}, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_data", wr_data, 0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    idle(1);

    // Loads with sign/zero extension; upper address bits beyond DEPTH are dropped
    do_load(3'd0, 32'h0001_0003, 32'h0000_0080, 2, 5'd7, 32'hFFFF_FF80);
    idle(1);
    check("rdata_held", resp_rdata, 32'hFFFF_FF80);
    do_load(3'd4, 32'h0000_0003, 32'h0000_0080, 2, 5'd7, 32'h0000_0080);
    idle(1);
    do_load(3'd0, 32'h0000_0005, 32'hABCD_EF7F, 1, 5'd7, 32'h0000_007F);
    idle(1);
    do_load(3'd1, 32'h0000_0002, 32'h1234_8001, 3, 5'd15, 32'hFFFF_8001);
    idle(1);
    do_load(3'd5, 32'h0000_0002, 32'h1234_8001, 3, 5'd15, 32'h0000_8001);
    idle(1);
    do_load(3'd2, 32'h0000_0004, 32'hCAFE_F00D, 1, 5'd31, 32'hCAFE_F00D);
    idle(1);

    // Stores
    do_store(3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 3, 5'd31);
    idle(1);
    do_store(3'd0, 32'h0000_0011, 32'h0000_00A5, 1, 5'd7);
    idle(1);
    do_store(3'd1, 32'h0000_0012, 32'h0000_BEEF, 2, 5'd15);
    idle(1);

    // Rejected requests
    do_err(1'b0, 3'd1, 32'h0000_0001, 2'b01);
    idle(1);
    do_err(1'b0, 3'd2, 32'h0000_0006, 2'b01);
    idle(1);
    do_err(1'b1, 3'd2, 32'h0000_0002, 2'b01);
    idle(1);
    do_err(1'b1, 3'd1, 32'h0000_0003, 2'b01);
    idle(1);
    do_err(1'b0, 3'd3, 32'h0000_0000, 2'b10);
    idle(1);
    do_err(1'b0, 3'd6, 32'h0000_0000, 2'b10);
    idle(1);
    do_err(1'b1, 3'd3, 32'h0000_0000, 2'b10);
    idle(1);

    // Timeout: no response for TIMEOUT=4 cycles, then a late response is ignored
    check("to_ready", req_ready, 1);
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'd2; req_address = 32'h0000_0020;
    expect_resp(32'h0, 2'b11);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      req_valid = 1'b0;
      check("to_rd_enable", rd_enable, 1);
      check("to_no_early_resp", resp_valid, 0);
    end
    @(negedge clock);
    check("to_rd_enable_drop", rd_enable, 0);
    check("to_resp_valid", resp_valid, 1);
    rd_response = 1'b1;
    rd_data     = 32'h7777_7777;
    @(negedge clock);
    rd_response = 1'b0;
    check("late_resp_ignored", resp_valid, 0);
    check("late_no_rd", rd_enable, 0);
    idle(2);

    // Asynchronous reset in the middle of a read abandons it
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'd2; req_address = 32'h0000_0040;
    @(negedge clock);
    req_valid = 1'b0;
    check("pre_rst_rd_enable", rd_enable, 1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_rd_enable", rd_enable, 0);
    check("arst_rd_address", {16'd0, rd_address}, 0);
    check("arst_ready", req_ready, 1);
    check("arst_resp_valid", resp_valid, 0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    idle(3);
    do_load(3'd2, 32'h0000_0008, 32'h0123_4567, 2, 5'd31, 32'h0123_4567);
    idle(1);

    // Back-to-back: load issued in the store's resp_valid cycle
    do_store(3'd2, 32'h0000_0030, 32'h55AA_55AA, 1, 5'd31);
    do_load(3'd2, 32'h0000_0030, 32'h55AA_55AA, 2, 5'd31, 32'h55AA_55AA);
    idle(2);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
